// File: rtl/pointer_accum_if.sv
// Mouse packet channel from the packet decoder to the cursor tracker.
// Carries signed X/Y motion, per-axis overflow flags and the button bits.
// Single valid/ready handshake; a packet transfers on valid && ready.
interface pointer_accum_if;
    logic       pkt_valid;
    logic       pkt_ready;
    logic [7:0] X_displ;
    logic [7:0] Y_displ;
    logic       X_ovf;
    logic       Y_ovf;
    logic [2:0] buttons;    // {middle, right, left}

    modport master (
        output pkt_valid, X_displ, Y_displ, X_ovf, Y_ovf, buttons,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid, X_displ, Y_displ, X_ovf, Y_ovf, buttons,
        output pkt_ready
    );
endinterface

// File: rtl/pointer_accum.sv
// Cursor tracker: scales mouse motion by 2^-SHIFT with carried residual, clamps to screen.
// Latency: packet accepted on edge N, outputs update on edge N+2, next accept on edge N+3.
// Backpressure: pkt_ready is high only in IDLE; valid seen in CALC/COMMIT is ignored.
module pointer_accum #(
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479,
    parameter int SIZE  = 4,
    parameter int SHIFT = 1,
    parameter int POS_W = 10
) (
    input  logic             frame_clk,
    input  logic             Reset,
    pointer_accum_if.slave   pkt,
    output logic [POS_W-1:0] X_pos,
    output logic [POS_W-1:0] Y_pos,
    output logic [POS_W-1:0] Size,
    output logic             draw,
    output logic             erase,
    output logic             moved
);

    localparam logic [POS_W-1:0]  X_CTR = POS_W'((X_MAX + 1) / 2);
    localparam logic [POS_W-1:0]  Y_CTR = POS_W'((Y_MAX + 1) / 2);
    localparam logic signed [11:0] X_LO = 12'(SIZE);
    localparam logic signed [11:0] X_HI = 12'(X_MAX - SIZE);
    localparam logic signed [11:0] Y_LO = 12'(SIZE);
    localparam logic signed [11:0] Y_HI = 12'(Y_MAX - SIZE);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    state_t state_q, state_d;

    // latched packet
    logic [7:0] dx_q, dy_q;
    logic       xovf_q, yovf_q;
    logic [2:0] btn_q;

    // motion split into integer step and fractional residual
    logic signed [11:0] acc_x, acc_y;
    logic signed [11:0] step_x_d, step_y_d, step_x_q, step_y_q;
    logic signed [11:0] rn_x_d, rn_y_d, rn_x_q, rn_y_q;

    // architectural state
    logic signed [11:0] res_x_q, res_y_q, res_x_d, res_y_d;
    logic [POS_W-1:0]   x_pos_q, y_pos_q, x_pos_d, y_pos_d;
    logic               mid_prev_q, draw_q, erase_q, moved_q;

    logic signed [11:0] sum_x, sum_y;
    logic               accept, mid_rise;

    function automatic logic signed [11:0] clamp12(input logic signed [11:0] v,
                                                   input logic signed [11:0] lo,
                                                   input logic signed [11:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

    assign pkt.pkt_ready = (state_q == IDLE);
    assign accept        = (state_q == IDLE) && pkt.pkt_valid;

    // State register
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: fixed three-cycle walk once a packet is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pkt.pkt_valid) state_d = CALC;
            CALC:    state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the packet on the accepting edge
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            dx_q   <= '0;
            dy_q   <= '0;
            xovf_q <= 1'b0;
            yovf_q <= 1'b0;
            btn_q  <= '0;
        end else if (accept) begin
            dx_q   <= pkt.X_displ;
            dy_q   <= pkt.Y_displ;
            xovf_q <= pkt.X_ovf;
            yovf_q <= pkt.Y_ovf;
            btn_q  <= pkt.buttons;
        end
    end

    // Split residual+motion into a floor step and a non-negative remainder
    always_comb begin
        acc_x    = res_x_q + $signed({{4{dx_q[7]}}, dx_q});
        acc_y    = res_y_q + $signed({{4{dy_q[7]}}, dy_q});
        step_x_d = acc_x >>> SHIFT;
        step_y_d = acc_y >>> SHIFT;
        rn_x_d   = acc_x - (step_x_d <<< SHIFT);
        rn_y_d   = acc_y - (step_y_d <<< SHIFT);
        if (xovf_q) begin
            step_x_d = '0;
            rn_x_d   = '0;
        end
        if (yovf_q) begin
            step_y_d = '0;
            rn_y_d   = '0;
        end
    end

    // Hold the CALC results for the COMMIT cycle
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            step_x_q <= '0;
            step_y_q <= '0;
            rn_x_q   <= '0;
            rn_y_q   <= '0;
        end else if (state_q == CALC) begin
            step_x_q <= step_x_d;
            step_y_q <= step_y_d;
            rn_x_q   <= rn_x_d;
            rn_y_q   <= rn_y_d;
        end
    end

    // New position: clamped motion, or recentre on a middle-button press
    always_comb begin
        sum_x    = $signed(12'(x_pos_q)) + step_x_q;
        sum_y    = $signed(12'(y_pos_q)) + step_y_q;
        mid_rise = btn_q[2] && !mid_prev_q;
        x_pos_d  = POS_W'(clamp12(sum_x, X_LO, X_HI));
        y_pos_d  = POS_W'(clamp12(sum_y, Y_LO, Y_HI));
        res_x_d  = rn_x_q;
        res_y_d  = rn_y_q;
        if (mid_rise) begin
            x_pos_d = X_CTR;
            y_pos_d = Y_CTR;
            res_x_d = '0;
            res_y_d = '0;
        end
    end

    // Commit position, residuals and buttons; moved pulses for one cycle
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            x_pos_q    <= X_CTR;
            y_pos_q    <= Y_CTR;
            res_x_q    <= '0;
            res_y_q    <= '0;
            mid_prev_q <= 1'b0;
            draw_q     <= 1'b0;
            erase_q    <= 1'b0;
            moved_q    <= 1'b0;
        end else begin
            moved_q <= 1'b0;
            if (state_q == COMMIT) begin
                x_pos_q    <= x_pos_d;
                y_pos_q    <= y_pos_d;
                res_x_q    <= res_x_d;
                res_y_q    <= res_y_d;
                mid_prev_q <= btn_q[2];
                draw_q     <= btn_q[0];
                erase_q    <= btn_q[1] && !btn_q[0];
                moved_q    <= (x_pos_d != x_pos_q) || (y_pos_d != y_pos_q);
            end
        end
    end

    assign X_pos = x_pos_q;
    assign Y_pos = y_pos_q;
    assign Size  = POS_W'(SIZE);
    assign draw  = draw_q;
    assign erase = erase_q;
    assign moved = moved_q;

endmodule
